// File: rtl/ant_pkg.sv
// Shared move encodings, FSM state enum and turn helpers for the ant pilot.
// Used by the top-level pilot and the loop tracker.
package ant_pkg;

  typedef enum logic [1:0] {
    STAY    = 2'b00,
    FORWARD = 2'b01,
    TURN_L  = 2'b10,
    TURN_R  = 2'b11
  } move_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    FWD    = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // hand 0 follows the right wall, hand 1 follows the left wall
  function automatic move_e turn_toward(input logic hand);
    return hand ? TURN_L : TURN_R;
  endfunction

  function automatic move_e turn_away(input logic hand);
    return hand ? TURN_R : TURN_L;
  endfunction

endpackage

// File: rtl/ant_loop_tracker.sv
// Pheromone epoch and revisit counter; swaps the follow hand after LOOP_LIMIT revisits.
// Updates on the edge that ends a successful CHECK; no backpressure.
module ant_loop_tracker
  import ant_pkg::*;
#(
  parameter int PH_WIDTH   = 4,
  parameter int START_HAND = 0,
  parameter int LOOP_LIMIT = 3,
  parameter int PHERO_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                check_stb_i,
  input  logic [PH_WIDTH-1:0] ph_detected_i,
  output logic [PH_WIDTH-1:0] epoch_o,
  output logic                hand_o
);

  logic [PH_WIDTH-1:0] epoch_q, epoch_d;
  logic [7:0]          loop_cnt_q, loop_cnt_d;
  logic                hand_q, hand_d;
  logic                revisit;

  assign revisit = (PHERO_EN != 0) && check_stb_i && (ph_detected_i == epoch_q);

  always_comb begin
    epoch_d    = epoch_q;
    loop_cnt_d = loop_cnt_q;
    hand_d     = hand_q;
    if (revisit) begin
      if (loop_cnt_q == 8'(LOOP_LIMIT - 1)) begin
        loop_cnt_d = '0;
        hand_d     = ~hand_q;
        // Epoch skips 0 so a dropped code is never confused with "no pheromone"
        epoch_d    = (epoch_q == {PH_WIDTH{1'b1}}) ? PH_WIDTH'(1) : epoch_q + PH_WIDTH'(1);
      end else begin
        loop_cnt_d = loop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q    <= PH_WIDTH'(1);
      loop_cnt_q <= '0;
      hand_q     <= 1'(START_HAND);
    end else begin
      epoch_q    <= epoch_d;
      loop_cnt_q <= loop_cnt_d;
      hand_q     <= hand_d;
    end
  end

  assign epoch_o = epoch_q;
  assign hand_o  = hand_q;

endmodule

// File: rtl/ant_pilot.sv
// Wall-following maze pilot with pheromone loop escape; all outputs registered.
// One action per cycle, sensors consumed the cycle after each move; no backpressure.
module ant_pilot
  import ant_pkg::*;
#(
  parameter int PH_WIDTH   = 4,
  parameter int START_HAND = 0,
  parameter int LOOP_LIMIT = 3,
  parameter int PHERO_EN   = 1,
  parameter int STEP_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ant_r,
  input  logic                ant_l,
  input  logic                hit,
  input  logic                escape,
  input  logic [PH_WIDTH-1:0] ph_detected,
  output logic [1:0]          move,
  output logic [PH_WIDTH-1:0] ph_drop,
  output logic                done,
  output logic                hand,
  output logic [STEP_W-1:0]   steps
);

  state_e              state_q;
  move_e               move_q;
  logic [PH_WIDTH-1:0] drop_q;
  logic                done_q;
  logic                turned_q;
  logic [STEP_W-1:0]   steps_q;

  logic [PH_WIDTH-1:0] epoch;
  logic                hand_cur;
  logic                follow_wall;
  logic                check_stb;

  assign follow_wall = hand_cur ? ant_l : ant_r;
  assign check_stb   = (state_q == CHECK) && !hit && !escape;

  ant_loop_tracker #(
    .PH_WIDTH  (PH_WIDTH),
    .START_HAND(START_HAND),
    .LOOP_LIMIT(LOOP_LIMIT),
    .PHERO_EN  (PHERO_EN)
  ) u_loop_tracker (
    .clk          (clk),
    .rst          (rst),
    .check_stb_i  (check_stb),
    .ph_detected_i(ph_detected),
    .epoch_o      (epoch),
    .hand_o       (hand_cur)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      move_q   <= STAY;
      drop_q   <= '0;
      done_q   <= 1'b0;
      turned_q <= 1'b0;
      steps_q  <= '0;
    end else begin
      drop_q <= '0;
      if (escape) begin
        state_q <= DONE;
        move_q  <= STAY;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= DECIDE;
            move_q  <= STAY;
          end
          DECIDE: begin
            // Only one speculative turn toward the open side per step
            if (!follow_wall && !turned_q) begin
              move_q   <= turn_toward(hand_cur);
              turned_q <= 1'b1;
              state_q  <= FWD;
            end else begin
              move_q  <= FORWARD;
              state_q <= CHECK;
            end
          end
          FWD: begin
            move_q  <= FORWARD;
            state_q <= CHECK;
          end
          CHECK: begin
            if (hit) begin
              move_q <= turn_away(hand_cur);
            end else begin
              move_q   <= STAY;
              turned_q <= 1'b0;
              drop_q   <= epoch;
              if (steps_q != {STEP_W{1'b1}}) steps_q <= steps_q + STEP_W'(1);
            end
            state_q <= DECIDE;
          end
          DONE: begin
            move_q <= STAY;
            done_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            move_q  <= STAY;
          end
        endcase
      end
    end
  end

  assign move    = move_q;
  assign ph_drop = (PHERO_EN != 0) ? drop_q : '0;
  assign done    = done_q;
  assign hand    = hand_cur;
  assign steps   = steps_q;

endmodule
